// File: rtl/gcn_if.sv
// Bus between gcn and its feature/weight memory, COO edge store and host.
// Carries start/done, the memory read port, the edge read port and the per-node answers.
interface gcn_if #(
  parameter int WEIGHT_ROWS       = 96,
  parameter int WEIGHT_WIDTH      = 5,
  parameter int FEATURE_ROWS      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_NUM_OF_ROWS   = 2,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int ADDRESS_WIDTH     = 13,
  parameter int MAX_ADDRESS_WIDTH = 2
);
  logic                              start;
  logic [WEIGHT_WIDTH-1:0]           data_in [0:WEIGHT_ROWS-1];
  logic [COO_NUM_OF_ROWS*COO_BW-1:0] coo_in;
  logic [COO_BW-1:0]                 coo_address;
  logic [ADDRESS_WIDTH-1:0]          read_address;
  logic                              enable_read;
  logic                              done;
  logic [MAX_ADDRESS_WIDTH-1:0]      max_addi_answer [0:FEATURE_ROWS-1];

  modport master (
    output start, data_in, coo_in,
    input  coo_address, read_address, enable_read, done, max_addi_answer
  );

  modport slave (
    input  start, data_in, coo_in,
    output coo_address, read_address, enable_read, done, max_addi_answer
  );
endinterface

// File: rtl/gcn.sv
// Single-stage graph convolution: FM*WM transform, COO neighbour aggregation, per-node argmax.
// Optional macro GCN_SELF_LOOP_EN seeds the aggregate with each node's own transform (A+I).
module gcn #(
  parameter int FEATURE_COLS      = 96,
  parameter int WEIGHT_ROWS       = 96,
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_COLS       = 3,
  parameter int FEATURE_WIDTH     = 5,
  parameter int WEIGHT_WIDTH      = 5,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH     = 13,
  parameter int NUM_OF_NODES      = 6,
  parameter int COO_NUM_OF_COLS   = 6,
  parameter int COO_NUM_OF_ROWS   = 2,
  parameter int COO_BW            = $clog2(COO_NUM_OF_COLS),
  parameter int MAX_ADDRESS_WIDTH = 2
) (
  input logic  clk,
  input logic  reset,
  gcn_if.slave bus
);
  localparam int IDX_W = $clog2(FEATURE_ROWS > WEIGHT_COLS ? FEATURE_ROWS : WEIGHT_COLS);
  localparam int FEAT_BASE = 512;

  typedef enum logic [2:0] {IDLE, LOAD_W, XFORM, AGG, ARGMAX, DONE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             idx;
  logic [WEIGHT_WIDTH-1:0]      w      [0:WEIGHT_COLS-1][0:WEIGHT_ROWS-1];
  logic [DOT_PROD_WIDTH-1:0]    fmwm   [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    adj    [0:FEATURE_ROWS-1][0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    dot    [0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    fm_s   [0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    fm_d   [0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]    best;
  logic [MAX_ADDRESS_WIDTH-1:0] amax   [0:FEATURE_ROWS-1];
  logic [MAX_ADDRESS_WIDTH-1:0] answer [0:FEATURE_ROWS-1];
  logic [COO_BW-1:0]            src, dst, coo_addr;
  logic [ADDRESS_WIDTH-1:0]     rd_addr;
  logic                         rd_en, done_q, edge_ok;

  assign src = bus.coo_in[COO_NUM_OF_ROWS*COO_BW-1 -: COO_BW];
  assign dst = bus.coo_in[COO_BW-1:0];
  assign edge_ok = (src != '0) && (dst != '0) &&
                   (src <= COO_BW'(NUM_OF_NODES)) && (dst <= COO_BW'(NUM_OF_NODES));

  assign bus.coo_address     = coo_addr;
  assign bus.read_address    = rd_addr;
  assign bus.enable_read     = rd_en;
  assign bus.done            = done_q;
  assign bus.max_addi_answer = answer;

  // All class columns of the current feature row are reduced in the same cycle.
  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      dot[c] = '0;
      for (int i = 0; i < FEATURE_COLS; i++)
        dot[c] = dot[c] + DOT_PROD_WIDTH'(bus.data_in[i]) * DOT_PROD_WIDTH'(w[c][i]);
    end
  end

  always_comb begin
    for (int c = 0; c < WEIGHT_COLS; c++) begin
      fm_s[c] = '0;
      fm_d[c] = '0;
    end
    for (int m = 0; m < FEATURE_ROWS; m++) begin
      if (src == COO_BW'(m + 1)) fm_s = fmwm[m];
      if (dst == COO_BW'(m + 1)) fm_d = fmwm[m];
    end
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    best = '0;
    for (int n = 0; n < FEATURE_ROWS; n++) begin
      best    = adj[n][0];
      amax[n] = '0;
      for (int c = 1; c < WEIGHT_COLS; c++) begin
        if (adj[n][c] > best) begin
          best    = adj[n][c];
          amax[n] = MAX_ADDRESS_WIDTH'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      rd_addr  <= '0;
      rd_en    <= 1'b0;
      coo_addr <= '0;
      done_q   <= 1'b0;
      for (int c = 0; c < WEIGHT_COLS; c++)
        for (int i = 0; i < WEIGHT_ROWS; i++) w[c][i] <= '0;
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        answer[n] <= '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          fmwm[n][c] <= '0;
          adj[n][c]  <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state   <= LOAD_W;
            idx     <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
          end
        end
        LOAD_W: begin
          for (int k = 0; k < WEIGHT_COLS; k++)
            if (idx == IDX_W'(k)) w[k] <= bus.data_in;
          if (idx == IDX_W'(WEIGHT_COLS - 1)) begin
            state   <= XFORM;
            idx     <= '0;
            rd_addr <= ADDRESS_WIDTH'(FEAT_BASE);
          end else begin
            idx     <= idx + 1'b1;
            rd_addr <= ADDRESS_WIDTH'(idx) + 1'b1;
          end
        end
        XFORM: begin
          // The aggregate for each row is seeded as that row is transformed.
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            if (idx == IDX_W'(r)) begin
              fmwm[r] <= dot;
`ifdef GCN_SELF_LOOP_EN
              adj[r]  <= dot;
`else
              for (int c = 0; c < WEIGHT_COLS; c++) adj[r][c] <= '0;
`endif
            end
          end
          if (idx == IDX_W'(FEATURE_ROWS - 1)) begin
            state    <= AGG;
            idx      <= '0;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            coo_addr <= '0;
          end else begin
            idx     <= idx + 1'b1;
            rd_addr <= ADDRESS_WIDTH'(FEAT_BASE + 1) + ADDRESS_WIDTH'(idx);
          end
        end
        AGG: begin
          if (edge_ok) begin
            for (int n = 0; n < FEATURE_ROWS; n++) begin
              if (src == COO_BW'(n + 1)) begin
                for (int c = 0; c < WEIGHT_COLS; c++) adj[n][c] <= adj[n][c] + fm_d[c];
              end else if (dst == COO_BW'(n + 1)) begin
                for (int c = 0; c < WEIGHT_COLS; c++) adj[n][c] <= adj[n][c] + fm_s[c];
              end
            end
          end
          if (coo_addr == COO_BW'(COO_NUM_OF_COLS - 1)) begin
            state    <= ARGMAX;
            coo_addr <= '0;
          end else begin
            coo_addr <= coo_addr + 1'b1;
          end
        end
        ARGMAX: begin
          answer <= amax;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gcn.sv
// Directed self-checking bench for gcn: reset, address/latency sequence, isolated nodes,
// overflow, mid-run reset and self-loop behaviour.
module tb_gcn;
  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  logic [4:0] wmem [0:2][0:95];
  logic [4:0] fmem [0:5][0:95];
  logic [2:0] esrc [0:5];
  logic [2:0] edst [0:5];

  gcn_if bus ();
  gcn dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 96; i++) bus.data_in[i] = '0;
    for (int k = 0; k < 3; k++)
      if (bus.read_address == 13'(k)) bus.data_in = wmem[k];
    for (int r = 0; r < 6; r++)
      if (bus.read_address == 13'(512 + r)) bus.data_in = fmem[r];
    bus.coo_in = '0;
    for (int e = 0; e < 6; e++)
      if (bus.coo_address == 3'(e)) bus.coo_in = {esrc[e], edst[e]};
  end

  task automatic do_reset();
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic set_mem(input int fval, input int w0, input int w1, input int w2);
    for (int i = 0; i < 96; i++) begin
      wmem[0][i] = 5'(w0);
      wmem[1][i] = 5'(w1);
      wmem[2][i] = 5'(w2);
      for (int r = 0; r < 6; r++) fmem[r][i] = 5'(fval);
    end
  endtask

  task automatic set_edge(input int e, input int s, input int d);
    esrc[e] = 3'(s);
    edst[e] = 3'(d);
  endtask

  // Leaves the bench 1 time unit after the edge that samples start.
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    total_cnt++;
    if (bus.done !== 1'b1) $display("FAIL %s_done_timeout got=%b want=1", name, bus.done);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done);
    else pass_cnt++;
    total_cnt++;
    if (bus.enable_read !== 1'b0) $display("FAIL reset_en got=%b want=0", bus.enable_read);
    else pass_cnt++;
    total_cnt++;
    if (bus.read_address !== 13'd0) $display("FAIL reset_raddr got=%0d want=0", bus.read_address);
    else pass_cnt++;
    total_cnt++;
    if (bus.coo_address !== 3'd0) $display("FAIL reset_coo got=%0d want=0", bus.coo_address);
    else pass_cnt++;
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (bus.max_addi_answer[n] !== 2'd0)
        $display("FAIL reset_ans%0d got=%0d want=0", n, bus.max_addi_answer[n]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sequence();
    logic [12:0] ea;
    do_reset();
    set_mem(1, 1, 2, 3);
    set_edge(0, 1, 2); set_edge(1, 3, 4); set_edge(2, 5, 6);
    set_edge(3, 0, 3); set_edge(4, 7, 1); set_edge(5, 0, 0);
    pulse_start();
    for (int j = 0; j <= 16; j++) begin
      if (j <= 8) begin
        ea = (j < 3) ? 13'(j) : 13'(512 + j - 3);
        total_cnt++;
        if (bus.read_address !== ea || bus.enable_read !== 1'b1)
          $display("FAIL seq_raddr_e%0d got=%0d/%b want=%0d/1", j, bus.read_address, bus.enable_read, ea);
        else pass_cnt++;
      end else if (j <= 14) begin
        total_cnt++;
        if (bus.coo_address !== 3'(j - 9) || bus.enable_read !== 1'b0)
          $display("FAIL seq_coo_e%0d got=%0d/%b want=%0d/0", j, bus.coo_address, bus.enable_read, j - 9);
        else pass_cnt++;
      end
      if (j == 15 || j == 16) begin
        total_cnt++;
        if (bus.done !== (j == 16))
          $display("FAIL seq_done_e%0d got=%b want=%b", j, bus.done, j == 16);
        else pass_cnt++;
      end
      if (j < 16) begin
        @(posedge clk);
        #1;
      end
    end
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (bus.max_addi_answer[n] !== 2'd2)
        $display("FAIL seq_ans%0d got=%0d want=2", n, bus.max_addi_answer[n]);
      else pass_cnt++;
    end
    // A later start must not disturb held results.
    @(negedge clk) bus.start = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b0;
    total_cnt++;
    if (bus.done !== 1'b1 || bus.max_addi_answer[3] !== 2'd2 || bus.enable_read !== 1'b0)
      $display("FAIL hold_done got=%b/%0d/%b want=1/2/0", bus.done, bus.max_addi_answer[3], bus.enable_read);
    else pass_cnt++;
  endtask

  task automatic test_isolated();
    do_reset();
    set_mem(1, 1, 2, 3);
    for (int e = 0; e < 6; e++) set_edge(e, 1, 2);
    pulse_start();
    wait_done("iso");
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (bus.max_addi_answer[n] !== ((n < 2) ? 2'd2 : 2'd0))
        $display("FAIL iso_ans%0d got=%0d want=%0d", n, bus.max_addi_answer[n], (n < 2) ? 2 : 0);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    set_mem(31, 31, 31, 31);
    set_edge(0, 1, 2); set_edge(1, 3, 4); set_edge(2, 5, 6);
    set_edge(3, 2, 2); set_edge(4, 4, 5); set_edge(5, 6, 1);
    pulse_start();
    wait_done("ovf");
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (bus.max_addi_answer[n] !== 2'd0)
        $display("FAIL ovf_ans%0d got=%0d want=0", n, bus.max_addi_answer[n]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mem(1, 1, 2, 3);
    set_edge(0, 1, 2); set_edge(1, 3, 4); set_edge(2, 5, 6);
    set_edge(3, 0, 0); set_edge(4, 0, 0); set_edge(5, 0, 0);
    pulse_start();
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (bus.done !== 1'b0 || bus.enable_read !== 1'b0 || bus.read_address !== 13'd0 || bus.coo_address !== 3'd0)
      $display("FAIL midrst_outputs got=%b/%b/%0d/%0d want=0/0/0/0",
               bus.done, bus.enable_read, bus.read_address, bus.coo_address);
    else pass_cnt++;
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.enable_read !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL midrst_idle got=%b/%b want=0/0", bus.enable_read, bus.done);
    else pass_cnt++;
    pulse_start();
    wait_done("midrst");
    for (int n = 0; n < 6; n++) begin
      total_cnt++;
      if (bus.max_addi_answer[n] !== 2'd2)
        $display("FAIL midrst_ans%0d got=%0d want=2", n, bus.max_addi_answer[n]);
      else pass_cnt++;
    end
  endtask

  task automatic test_self_loop();
    logic [1:0] iso_exp;
`ifdef GCN_SELF_LOOP_EN
    iso_exp = 2'd1;
`else
    iso_exp = 2'd0;
`endif
    do_reset();
    set_mem(1, 1, 3, 2);
    for (int e = 0; e < 6; e++) set_edge(e, 1, 2);
    pulse_start();
    wait_done("self");
    total_cnt++;
    if (bus.max_addi_answer[0] !== 2'd1)
      $display("FAIL self_ans0 got=%0d want=1", bus.max_addi_answer[0]);
    else pass_cnt++;
    total_cnt++;
    if (bus.max_addi_answer[2] !== iso_exp)
      $display("FAIL self_ans2 got=%0d want=%0d", bus.max_addi_answer[2], iso_exp);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    set_mem(0, 0, 0, 0);
    for (int e = 0; e < 6; e++) set_edge(e, 0, 0);
    test_reset();
    test_sequence();
    test_isolated();
    test_overflow();
    test_reset_mid();
    test_self_loop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/gcn.md
# gcn

Two-layer-free, single-stage graph convolution engine: computes the node-feature transform FM·WM, aggregates neighbour results over a COO-encoded undirected graph, and outputs per-node argmax class indices. Sits between the external feature/weight memory and the COO edge store; the host pulses `start` after reset and waits for `done`.

## Interface
- FEATURE_COLS, 96, features per node (= WEIGHT_ROWS)
- WEIGHT_ROWS, 96, weight-column length
- FEATURE_ROWS, 6, number of nodes
- WEIGHT_COLS, 3, number of classes
- FEATURE_WIDTH, 5, unsigned feature element width
- WEIGHT_WIDTH, 5, unsigned weight element width
- DOT_PROD_WIDTH, 16, transform/aggregate result width
- ADDRESS_WIDTH, 13, memory read-address width
- NUM_OF_NODES, 6; COO_NUM_OF_COLS, 6 (edge count); COO_NUM_OF_ROWS, 2
- COO_BW, $clog2(COO_NUM_OF_COLS), node-index/edge-address width
- MAX_ADDRESS_WIDTH, 2, argmax index width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin computation (level, sampled in IDLE)
- data_in  in  WEIGHT_ROWS×WEIGHT_WIDTH unpacked [0:WEIGHT_ROWS-1]  memory row returned combinationally for `read_address`
- coo_in  in  2·COO_BW  {source node, destination node} of edge `coo_address`; upper COO_BW bits = source
- coo_address  out  COO_BW  edge index being read
- read_address  out  ADDRESS_WIDTH  0..WEIGHT_COLS-1 = weight column; 512+r = feature row r
- enable_read  out  1  high while read_address is valid
- done  out  1  results valid
- max_addi_answer  out  FEATURE_ROWS×MAX_ADDRESS_WIDTH unpacked [0:FEATURE_ROWS-1]  per-node argmax class

## Operation
- FSM: IDLE → LOAD_W → XFORM → AGG → ARGMAX → DONE.
- IDLE: outputs at reset values; move to LOAD_W when start=1.
- LOAD_W: k=0..WEIGHT_COLS-1, read_address=k, enable_read=1; latch data_in into weight column register k.
- XFORM: r=0..FEATURE_ROWS-1, read_address=512+r, enable_read=1; FMWM[r][c] = Σ_i data_in[i]·W[c][i], all c in parallel, unsigned, truncated modulo 2^DOT_PROD_WIDTH.
- AGG: e=0..COO_NUM_OF_COLS-1, coo_address=e, enable_read=0; nodes are 1-based (value 1..NUM_OF_NODES); for edge (s,d): ADJ[s-1] += FMWM[d-1] and ADJ[d-1] += FMWM[s-1]; if s==d add once. ADJ cleared to 0 on entry; modulo 2^DOT_PROD_WIDTH. Node value 0 or >NUM_OF_NODES: edge ignored.
- ARGMAX: per node, index of largest ADJ[n][c], unsigned compare; ties → lowest index; registered into max_addi_answer.
- DONE: done=1, outputs held until reset; start ignored.
- start changes outside IDLE have no effect.

## Timing
- Reset values: done=0, enable_read=0, read_address=0, coo_address=0, max_addi_answer all 0; FSM IDLE; internal registers cleared.
- Edge E0 samples start=1 in IDLE. LOAD_W covers edges E1–E3, XFORM E4–E9, AGG E10–E15, ARGMAX result registered at E16; done=1 and answers valid after E16 (16 cycles after start sampled, default parameters).
- read_address/coo_address are registered; data_in/coo_in must be valid in the same cycle (combinational source).
- Reset asserted mid-operation: immediate abort to IDLE, all outputs to reset values; new run requires start after reset release.

## Configuration
- GCN_SELF_LOOP_EN: when defined, ADJ is initialised to FMWM on AGG entry (aggregation over A+I). When undefined (default), ADJ initialised to 0 (pure A).

## Test plan
- All features 1, weight column c all (c+1), edges (1,2),(3,4),(5,6) → FMWM row = 96,192,288; every max_addi_answer = 2; done 16 cycles after start.
- Address sequence: read_address 0,1,2,512..517 with enable_read=1, then coo_address 0..5 with enable_read=0.
- Node with no incident edges (edges all between 1–2 repeated) → nodes 3–6 ADJ all 0 → answer 0 (tie, lowest index).
- Overflow: all features 31, all weights 31 → FMWM = 92256 mod 65536 = 26720 per entry; ties → answer 0.
- Reset asserted during XFORM → done=0, addresses 0 immediately; re-run with start gives correct answers.
- With GCN_SELF_LOOP_EN, isolated node whose column 1 dominates its own FMWM → answer 1 (0 without macro).
